// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until the owner releases,
// then rotated to the next requester after the previous owner.
// Optional owner preemption after MAX_HOLD cycles: define TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  // Elaboration-time parameter sanity check
  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_grant_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_ptr;
  logic [ID_W-1:0]    scan_base;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;
  logic               owner_req;
  int unsigned        idx;

`ifdef TIMEOUT_EN
  localparam int unsigned HC_W = $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  logic [HC_W-1:0] hold_cnt;
`endif

  // Winner scan: starts after the owner while busy (owner excluded), after last_ptr while idle
  always_comb begin
    scan_base  = (state == BUSY) ? gnt_id : last_ptr;
    win_found  = 1'b0;
    win_id     = '0;
    idx        = 0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx = (32'(scan_base) + i) % NUM_REQ;
      if (req[ID_W'(idx)] && !(state == BUSY && ID_W'(idx) == scan_base)) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
    win_onehot = NUM_REQ'(1) << win_id;
    owner_req  = |(req & gnt);
  end

  // Grant state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ptr  <= ID_W'(NUM_REQ - 1);
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
`ifdef TIMEOUT_EN
      timeout   <= 1'b0;
      hold_cnt  <= '0;
`endif
    end else begin
`ifdef TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= BUSY;
            gnt       <= win_onehot;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
`ifdef TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (owner_req) begin
`ifdef TIMEOUT_EN
            if (hold_cnt == HOLD_LAST && win_found) begin
              last_ptr <= gnt_id;
              gnt      <= win_onehot;
              gnt_id   <= win_id;
              hold_cnt <= '0;
              timeout  <= 1'b1;
            end else if (hold_cnt != HOLD_LAST) begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
`endif
          end else begin
            last_ptr <= gnt_id;
            if (win_found) begin
              gnt      <= win_onehot;
              gnt_id   <= win_id;
`ifdef TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_id    <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random request traffic,
// checked each cycle against a behavioural round-robin model.
module tb_rr_grant_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned HOLD = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          timeout;

  int vectors;
  int miscompares;

  // Model state: owner index (-1 = idle), last owner pointer, hold cycles, pulse
  int m_owner;
  int m_last;
  int m_hold;
  bit m_to;

  rr_grant_arbiter #(.NUM_REQ(N), .ID_W(IW), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // First set request after base, wrapping; optionally skip base itself
  function automatic int pick(input int base, input logic [N-1:0] r, input bit skip_base);
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (base + k) % int'(N);
      if (!(skip_base && c == base) && r[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit timeout_on();
`ifdef TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = int'(N) - 1;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    int nxt;
    m_to = 1'b0;
    if (m_owner < 0) begin
      nxt = pick(m_last, r, 1'b0);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_hold  = 0;
      end
    end else if (r[m_owner]) begin
      nxt = pick(m_owner, r, 1'b1);
      if (timeout_on() && m_hold == int'(HOLD) - 1 && nxt >= 0) begin
        m_last  = m_owner;
        m_owner = nxt;
        m_hold  = 0;
        m_to    = 1'b1;
      end else if (m_hold < int'(HOLD) - 1) begin
        m_hold++;
      end
    end else begin
      m_last = m_owner;
      nxt    = pick(m_owner, r, 1'b1);
      m_owner = nxt;
      m_hold  = 0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check("gnt",       32'(gnt),       32'(eg));
    check("gnt_id",    32'(gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("timeout",   32'(timeout),   32'(m_to));
    check("onehot0",   32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    vectors     = 0;
    miscompares = 0;
    model_reset();

    // Reset with all requests up, then first grant goes to requester 0
    rst_n = 1'b0;
    req   = 4'b1111;
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111);

    // Fair rotation: owner drops for one cycle, then re-raises
    for (int k = 0; k < 8; k++) begin
      r = 4'b1111;
      r[m_owner] = 1'b0;
      step(r);
      step(4'b1111);
    end
    step(4'b0000);
    step(4'b0000);

    // Single requester, release, re-win
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    step(4'b0100);
    step(4'b0000);
    // One-cycle pulse while idle is granted, then dropped
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);

    // Handoff with wrap: owner 3, drop to req 0001
    step(4'b1000);
    step(4'b1001);
    step(4'b0001);
    step(4'b0000);
    // Owner 2 drops with 1101 pending -> 1000
    step(4'b0100);
    step(4'b1101);
    step(4'b1001);
    step(4'b0000);

    // Asynchronous reset mid-grant, then regrant
    step(4'b0010);
    step(4'b0010);
    async_reset_pulse();
    step(4'b0010);
    step(4'b0000);

    // Long hold with a competitor: preempts only with TIMEOUT_EN
    for (int k = 0; k < 20; k++) step(4'b0011);
    step(4'b0000);
    // Long hold alone: never preempted
    for (int k = 0; k < 100; k++) step(4'b0001);
    step(4'b0000);
    for (int k = 0; k < 100; k++) step(4'b0011);
    step(4'b0000);

    // Random traffic: each bit flips with probability 1/4, occasional async reset
    r = '0;
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < int'(N); b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      if ($urandom_range(199) == 0) async_reset_pulse();
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
